hls_xfft2real_div_31s_16s_16_seq: RTL
=====================================

Name: hls_xfft2real_div_31s_16s_16_seq

Overview:
- Iterative signed divider. It is the inverse datapath of the 16s x 16s -> 31s pipelined multiplier used in the xfft2real stage.
- Takes a 31-bit signed product-domain value and a 16-bit signed divisor, and returns a 16-bit signed quotient and remainder.
- Used to renormalise scaled spectral samples.
- Restoring shift-subtract on magnitudes, one quotient bit per enabled cycle, followed by a sign/saturation fix-up cycle; start/done handshake.

Parameters:
- ID, 32'd1, instance identifier; no functional effect.
- DIVIDEND_W, 31, dividend width (signed); also the number of iterations.
- DIVISOR_W, 16, divisor and remainder width (signed).
- QUOT_W, 16, quotient width (signed, saturating).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  request; sampled only in IDLE with ce=1.
- dividend  in  DIVIDEND_W  signed numerator.
- divisor  in  DIVISOR_W  signed denominator.
- busy  out  1  high from the accepted start until done is asserted.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- quot  out  QUOT_W  signed quotient, truncated toward zero, saturated.
- rem  out  DIVISOR_W  signed remainder; sign follows the dividend.
- div_by_zero  out  1  sticky with the result; divisor was 0.
- overflow  out  1  sticky with the result; true quotient was outside the QUOT_W range.

Behaviour:
- Reset:
  - reset_n low asynchronously forces state=IDLE.
  - busy=0, done=0, quot=0, rem=0, div_by_zero=0, overflow=0.
  - Counter and working registers are cleared.
  - Reset applied mid-CALC aborts the operation; no done is produced.
- Clock enable: every register update is qualified by ce. With ce=0 nothing changes, including the done pulse, which stretches while ce=0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 and ce=1 at edge T0: latch |dividend|, |divisor|, sign of dividend, and sign of the quotient (dividend sign XOR divisor sign).
  - Also at T0: cnt=DIVIDEND_W-1, busy=1, done=0, go to CALC.
  - Result outputs keep their previous values until FIX.
- CALC:
  - Each enabled edge shifts the partial remainder left, bringing in the next dividend MSB.
  - If partial remainder >= |divisor|, subtract and shift in quotient bit 1; otherwise shift in 0.
  - The partial remainder is DIVISOR_W+1 bits wide.
  - Exits to FIX after the cnt=0 iteration, i.e. DIVIDEND_W edges (T1..T31).
- FIX (edge T32):
  - Apply signs: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Saturate: a positive magnitude >32767 gives 32767 with overflow=1; a negative magnitude >32768 gives -32768 with overflow=1.
  - Divisor=0: quot=32767 if dividend>=0 else -32768; rem=0, div_by_zero=1, overflow=0.
  - In the same edge: done=1, busy=0, go to IDLE.
- Latency: with ce held high, done is high in the cycle after edge T0+DIVIDEND_W+1 (32 edges after start for the defaults).
- Throughput: a new start may be accepted at the edge where done is high, since the state is then IDLE. done falls at that edge.
- start while busy is ignored; it is not queued.
- div_by_zero and overflow are updated only at FIX and hold until the next FIX or reset.
- Edge case: |-32768| divisor is 32768, which fits the DIVISOR_W+1-bit magnitude path. A dividend of -2^30 is handled in a DIVIDEND_W-bit unsigned magnitude.

Test Plan:
- 1000/7 with ce=1 -> done exactly 32 edges after start; quot=142, rem=6, flags 0; busy high for 32 cycles.
- Sign cases: -1000/7 -> quot=-142, rem=-6; 1000/-7 -> quot=-142, rem=6; -1000/-7 -> quot=142, rem=-6.
- Saturation: (2^30-1)/1 -> quot=32767, overflow=1; -32768/1 -> quot=-32768, overflow=0; 32768/-1 -> quot=-32768, overflow=0; -2^30/-32768 -> quot=32767, overflow=1 (true quotient 32768).
- Divide by zero: 12345/0 -> quot=32767, rem=0, div_by_zero=1; -5/0 -> quot=-32768, div_by_zero=1; a following 10/3 clears the flags -> quot=3, rem=1.
- ce and handshake:
  - ce low for 5 cycles mid-CALC -> done arrives exactly 5 cycles later, results unchanged.
  - start pulsed while busy -> ignored, only one done.
  - Back-to-back start on the done cycle -> second result 32 edges later.
- Reset: reset_n low at CALC iteration 10 -> busy, done, quot and rem go to 0 immediately without a clock; no done after release; next start completes normally.

Source files
------------

// File: rtl/hls_xfft2real_div_31s_16s_16_seq.sv
// Iterative restoring signed divider for the xfft2real stage: a 31-bit product-domain
// value divided by a 16-bit divisor, one quotient bit per enabled cycle, then a sign/saturation fix-up.
module hls_xfft2real_div_31s_16s_16_seq #(
    parameter logic [31:0] ID         = 32'd1,
    parameter int          DIVIDEND_W = 31,
    parameter int          DIVISOR_W  = 16,
    parameter int          QUOT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ce,
    input  logic                        start,
    input  logic signed [DIVIDEND_W-1:0] dividend,
    input  logic signed [DIVISOR_W-1:0]  divisor,
    output logic                        busy,
    output logic                        done,
    output logic signed [QUOT_W-1:0]     quot,
    output logic signed [DIVISOR_W-1:0]  rem,
    output logic                        div_by_zero,
    output logic                        overflow
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    localparam logic [QUOT_W-1:0]     QMAX     = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]     QMIN     = {1'b1, {(QUOT_W-1){1'b0}}};
    localparam logic [DIVIDEND_W-1:0] QMAX_MAG = {{(DIVIDEND_W-QUOT_W){1'b0}}, QMAX};
    localparam logic [DIVIDEND_W-1:0] QMIN_MAG = {{(DIVIDEND_W-QUOT_W){1'b0}}, QMIN};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0]   dq_q, dq_d;
    logic [DIVISOR_W:0]      prem_q, prem_d;
    logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
    logic                    neg_dvd_q, neg_dvd_d;
    logic                    neg_quot_q, neg_quot_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [QUOT_W-1:0]       quot_q, quot_d;
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic                    dbz_q, dbz_d;
    logic                    ovf_q, ovf_d;

    logic [DIVIDEND_W-1:0]   dvd_mag;
    logic [DIVISOR_W-1:0]    dvs_mag;
    logic [DIVISOR_W:0]      prem_shift;
    logic [DIVISOR_W:0]      prem_sub;
    logic                    q_bit;
    logic [QUOT_W-1:0]       q_lo;
    logic [DIVISOR_W-1:0]    rmag;
    logic [QUOT_W-1:0]       fix_quot;
    logic [DIVISOR_W-1:0]    fix_rem;
    logic                    fix_ovf;
    logic                    fix_dbz;

    // The stored partial remainder is always below |divisor|, so its top bit is never consumed.
    logic unused_bits;
    assign unused_bits = ^{ID, prem_q[DIVISOR_W]};

    always_comb begin
        dvd_mag = dividend[DIVIDEND_W-1] ? $unsigned(-dividend) : $unsigned(dividend);
        dvs_mag = divisor[DIVISOR_W-1]   ? $unsigned(-divisor)  : $unsigned(divisor);

        prem_shift = {prem_q[DIVISOR_W-1:0], dq_q[DIVIDEND_W-1]};
        prem_sub   = prem_shift - {1'b0, dvs_q};
        q_bit      = (prem_shift >= {1'b0, dvs_q});

        q_lo = dq_q[QUOT_W-1:0];
        rmag = prem_q[DIVISOR_W-1:0];

        // Sign restoration and saturation of the finished magnitudes.
        fix_ovf = 1'b0;
        fix_dbz = 1'b0;
        fix_rem = neg_dvd_q ? (-rmag) : rmag;
        if (dvs_q == '0) begin
            fix_quot = neg_dvd_q ? QMIN : QMAX;
            fix_rem  = '0;
            fix_dbz  = 1'b1;
        end else if (neg_quot_q) begin
            if (dq_q > QMIN_MAG) begin
                fix_quot = QMIN;
                fix_ovf  = 1'b1;
            end else begin
                fix_quot = -q_lo;
            end
        end else begin
            if (dq_q > QMAX_MAG) begin
                fix_quot = QMAX;
                fix_ovf  = 1'b1;
            end else begin
                fix_quot = q_lo;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dq_d       = dq_q;
        prem_d     = prem_q;
        dvs_d      = dvs_q;
        neg_dvd_d  = neg_dvd_q;
        neg_quot_d = neg_quot_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dq_d       = dvd_mag;
                    prem_d     = '0;
                    dvs_d      = dvs_mag;
                    neg_dvd_d  = dividend[DIVIDEND_W-1];
                    neg_quot_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                    cnt_d      = CNT_W'(DIVIDEND_W - 1);
                    busy_d     = 1'b1;
                    state_d    = CALC;
                end
            end
            CALC: begin
                prem_d = q_bit ? prem_sub : prem_shift;
                dq_d   = {dq_q[DIVIDEND_W-2:0], q_bit};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                quot_d  = fix_quot;
                rem_d   = fix_rem;
                dbz_d   = fix_dbz;
                ovf_d   = fix_ovf;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Every register update is gated by ce, so a done pulse stretches while ce is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dq_q       <= '0;
            prem_q     <= '0;
            dvs_q      <= '0;
            neg_dvd_q  <= 1'b0;
            neg_quot_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (ce) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dq_q       <= dq_d;
            prem_q     <= prem_d;
            dvs_q      <= dvs_d;
            neg_dvd_q  <= neg_dvd_d;
            neg_quot_q <= neg_quot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
